obi_wb_bridge_pipe: RTL

OBI_WB_BRIDGE_PIPE -- requirements
Module: obi_wb_bridge_pipe

---
 rtl/obi_wb_bridge_pipe.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/obi_wb_bridge_pipe.sv
// OBI-to-Wishbone classic bridge: DEPTH-entry request FIFO feeding a single-outstanding bus FSM.
// Optional bus timeout is compiled in when OBI_WB_BRIDGE_TIMEOUT_EN is defined.
//
//   state | meaning
//   IDLE  | no transfer on the bus; pops the FIFO head when one is queued
//   BUS   | cyc/stb asserted with held address/data, waiting for ack/err (or timeout)
//   RESP  | one-cycle rvalid_o pulse carrying rdata_o/err_o
module obi_wb_bridge_pipe #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic                    wb_stb_o,
  output logic                    wb_cyc_o,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i
);

  localparam int BW    = DATA_WIDTH / 8;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
    $error("obi_wb_bridge_pipe: DATA_WIDTH must be 32 or 64");
  end
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("obi_wb_bridge_pipe: DEPTH must be a power of two from 2 to 16");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] fifo_adr_q [DEPTH];
  logic [DATA_WIDTH-1:0] fifo_dat_q [DEPTH];
  logic                  fifo_we_q  [DEPTH];
  logic [BW-1:0]         fifo_sel_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fifo_full, fifo_empty;
  logic             push, pop;

  logic [ADDR_WIDTH-1:0] wb_adr_q, wb_adr_d;
  logic [DATA_WIDTH-1:0] wb_dat_q, wb_dat_d;
  logic                  wb_we_q, wb_we_d;
  logic [BW-1:0]         wb_sel_q, wb_sel_d;
  logic                  wb_cyc_q, wb_cyc_d;
  logic                  rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  timeout;

  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign fifo_empty = (count_q == '0);
  assign gnt_o      = req_i & ~fifo_full;
  assign push       = req_i & gnt_o;

`ifdef OBI_WB_BRIDGE_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Fires in the TIMEOUT_CYCLES-th BUS cycle, so cyc is high exactly that many cycles.
  assign timeout = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q == IDLE) begin
      to_cnt_d = '0;
    end else if (state_q == BUS) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    wb_adr_d = wb_adr_q;
    wb_dat_d = wb_dat_q;
    wb_we_d  = wb_we_q;
    wb_sel_d = wb_sel_q;
    wb_cyc_d = wb_cyc_q;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          wb_adr_d = fifo_adr_q[rd_ptr_q];
          wb_dat_d = fifo_dat_q[rd_ptr_q];
          wb_we_d  = fifo_we_q[rd_ptr_q];
          wb_sel_d = fifo_sel_q[rd_ptr_q];
          wb_cyc_d = 1'b1;
          state_d  = BUS;
        end
      end
      BUS: begin
        // err outranks ack, and both outrank a timeout landing on the same cycle.
        if (wb_err_i) begin
          wb_cyc_d = 1'b0;
          rvalid_d = 1'b1;
          rdata_d  = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end else if (wb_ack_i) begin
          wb_cyc_d = 1'b0;
          rvalid_d = 1'b1;
          rdata_d  = wb_we_q ? '0 : wb_dat_i;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (timeout) begin
          wb_cyc_d = 1'b0;
          rvalid_d = 1'b1;
          rdata_d  = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        wb_cyc_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Payload storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_adr_q[wr_ptr_q] <= addr_i;
      fifo_dat_q[wr_ptr_q] <= wdata_i;
      fifo_we_q[wr_ptr_q]  <= we_i;
      fifo_sel_q[wr_ptr_q] <= be_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wb_adr_q <= '0;
      wb_dat_q <= '0;
      wb_we_q  <= 1'b0;
      wb_sel_q <= '0;
      wb_cyc_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wb_adr_q <= wb_adr_d;
      wb_dat_q <= wb_dat_d;
      wb_we_q  <= wb_we_d;
      wb_sel_q <= wb_sel_d;
      wb_cyc_q <= wb_cyc_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign wb_adr_o = wb_adr_q;
  assign wb_dat_o = wb_dat_q;
  assign wb_we_o  = wb_we_q;
  assign wb_sel_o = wb_sel_q;
  assign wb_cyc_o = wb_cyc_q;
  assign wb_stb_o = wb_cyc_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;

endmodule
